// File: rtl/wb_reorder.sv
// Writeback reorder buffer: captures completed descriptors by ROB slot and
// retires them strictly in allocation order through a registered valid/ready port.

module wb_rob_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic         clr,
  input  logic [W-1:0] wr_data,
  output logic         done,
  output logic [W-1:0] data
);

  // wr only fires on a non-done slot and clr only on a done one, so they never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      data <= '0;
    end else begin
      if (clr)     done <= 1'b0;
      else if (wr) done <= 1'b1;
      if (wr) data <= wr_data;
    end
  end

endmodule

module wb_reorder #(
  parameter int info_length    = 20,
  parameter int order_id       = 3,
  parameter int register_num   = 32,
  parameter int register_width = $clog2(register_num),
  parameter int rob_num        = 16,
  parameter int rob_width      = $clog2(rob_num)
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      wb_busy,
  input  logic                      reg0_ex_valid,
  input  logic                      reg0_ex_en,
  input  logic [info_length-1:0]    reg0_ex_info,
  input  logic [order_id-1:0]       reg0_ex_id,
  input  logic                      reg0_ex_so,
  input  logic [register_width-1:0] reg0_ex_data_entry,
  input  logic [rob_width-1:0]      reg0_ex_rob_entry,
  output logic                      wb_out_valid,
  input  logic                      wb_out_ready,
  output logic                      wb_out_en,
  output logic [info_length-1:0]    wb_out_info,
  output logic [order_id-1:0]       wb_out_id,
  output logic                      wb_out_so,
  output logic [register_width-1:0] wb_out_data_entry,
  output logic [rob_width-1:0]      wb_out_rob_entry,
  output logic                      rob_free_valid,
  output logic [rob_width-1:0]      rob_free_entry,
  output logic                      reg_free_valid,
  output logic [register_width-1:0] reg_free_entry,
  output logic                      err_dup
);

  typedef struct packed {
    logic                      en;
    logic [info_length-1:0]    info;
    logic [order_id-1:0]       id;
    logic                      so;
    logic [register_width-1:0] data_entry;
  } desc_t;

  localparam int DW = $bits(desc_t);
  localparam logic [rob_width:0]   ROB_LIM   = (rob_width+1)'(rob_num);
  localparam logic [rob_width-1:0] HEAD_LAST = rob_width'(rob_num - 1);

  logic [rob_num-1:0]          done, slot_wr, slot_clr;
  logic [rob_num-1:0][DW-1:0]  slot_q;
  logic [rob_width-1:0]        head;
  desc_t                       wr_desc, out_q;
  logic                        in_range, wr_ok, out_free, retire, accept;

  assign wr_desc  = '{en: reg0_ex_en, info: reg0_ex_info, id: reg0_ex_id,
                      so: reg0_ex_so, data_entry: reg0_ex_data_entry};
  assign in_range = {1'b0, reg0_ex_rob_entry} < ROB_LIM;
  assign wr_ok    = reg0_ex_valid && in_range && !done[reg0_ex_rob_entry];
  assign out_free = !wb_out_valid || wb_out_ready;
  // done[head] is the registered bit, so a same-cycle write to head is not bypassed
  assign retire   = done[head] && out_free;
  assign accept   = wb_out_valid && wb_out_ready;
  assign wb_busy  = wb_out_valid && !wb_out_ready;

  for (genvar g = 0; g < rob_num; g++) begin : g_slot
    assign slot_wr[g]  = wr_ok && (reg0_ex_rob_entry == rob_width'(g));
    assign slot_clr[g] = retire && (head == rob_width'(g));
    wb_rob_slot #(.W(DW)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .wr      (slot_wr[g]),
      .clr     (slot_clr[g]),
      .wr_data (wr_desc),
      .done    (done[g]),
      .data    (slot_q[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head             <= '0;
      wb_out_valid     <= 1'b0;
      out_q            <= '0;
      wb_out_rob_entry <= '0;
      rob_free_valid   <= 1'b0;
      rob_free_entry   <= '0;
      reg_free_valid   <= 1'b0;
      reg_free_entry   <= '0;
      err_dup          <= 1'b0;
    end else begin
      rob_free_valid <= retire;
      reg_free_valid <= accept;
      if (reg0_ex_valid && !wr_ok) err_dup <= 1'b1;
      if (accept) reg_free_entry <= out_q.data_entry;
      if (retire) begin
        wb_out_valid     <= 1'b1;
        out_q            <= desc_t'(slot_q[head]);
        wb_out_rob_entry <= head;
        rob_free_entry   <= head;
        head             <= (head == HEAD_LAST) ? '0 : head + 1'b1;
      end else if (accept) begin
        wb_out_valid <= 1'b0;
      end
    end
  end

  assign wb_out_en         = out_q.en;
  assign wb_out_info       = out_q.info;
  assign wb_out_id         = out_q.id;
  assign wb_out_so         = out_q.so;
  assign wb_out_data_entry = out_q.data_entry;

endmodule

// File: doc/wb_reorder.md
# wb_reorder

Writeback stage directly downstream of the execute stage. Captures every completed packet descriptor (lookup result or lookup-bypassed) into the reorder-buffer slot named by its `rob_entry`, then retires slots strictly in allocation order through a registered valid/ready output port. On retirement it returns the ROB slot to decode and, on output acceptance, frees the packet's data register. It drives `wb_busy` back to execute to stall it while the output is back-pressured.

## Interface
- `info_length`, 20, lookup side-band width
- `order_id`, 3, ordering-id width
- `register_num`, 32, data registers; `register_width = clogb(register_num)`
- `rob_num`, 16, ROB slots; `rob_width = clogb(rob_num)`
- `clk`  in  1  clock
- `rst`  in  1  reset: asynchronous, active-high; clock clk
- `wb_busy`  out  1  stall to execute
- `reg0_ex_valid`  in  1  descriptor from execute valid this cycle
- `reg0_ex_en`  in  1  1 = lookup result, 0 = lookup bypassed
- `reg0_ex_info` / `reg0_ex_id` / `reg0_ex_so`  in  info_length / order_id / 1  descriptor fields
- `reg0_ex_data_entry`  in  register_width  data register holding the packet
- `reg0_ex_rob_entry`  in  rob_width  target ROB slot (allocated by decode)
- `wb_out_valid`  out  1  retired descriptor valid
- `wb_out_ready`  in  1  downstream accepts
- `wb_out_en`, `wb_out_info`, `wb_out_id`, `wb_out_so`, `wb_out_data_entry`, `wb_out_rob_entry`  out  as inputs  retired fields
- `rob_free_valid`  out  1  one-cycle pulse: slot retired
- `rob_free_entry`  out  rob_width  freed slot
- `reg_free_valid`  out  1  one-cycle pulse: data register released
- `reg_free_entry`  out  register_width  released register
- `err_dup`  out  1  sticky: write to slot already holding an unretired descriptor, or `rob_entry >= rob_num`

## Operation
- Storage: per slot a `done` bit plus en/info/id/so/data_entry fields. `head` pointer has width rob_width.
- Write: if `reg0_ex_valid` and `done[rob_entry]==0` and `rob_entry < rob_num`, store the fields and set `done`. Otherwise drop the write and set `err_dup`.
- Output register free = `!wb_out_valid || wb_out_ready`.
- Retire, in the same cycle: if `done[head]` and the output register is free:
  - load the output register from slot `head`;
  - clear `done[head]`;
  - pulse `rob_free_valid` with `rob_free_entry = head` (registered, same edge);
  - `head <= (head == rob_num-1) ? 0 : head+1`.
- Only one retirement per cycle. A non-done head blocks all younger done slots.
- Accept: `wb_out_valid && wb_out_ready` pulses `reg_free_valid` with `reg_free_entry = wb_out_data_entry` (registered, next edge). It clears `wb_out_valid` unless a new retire loads it in the same cycle.
- `wb_busy = wb_out_valid && !wb_out_ready`, combinational, with no dependence on `reg0_ex_*`. Writes arriving while busy are still stored.
- `reg0_ex_so` and `reg0_ex_id` are carried through unchanged. The order is the ROB order.

## Timing
- Reset: `wb_out_valid`, `rob_free_valid`, `reg_free_valid`, `err_dup`, and all `done` bits = 0. `head` = 0. All output data = 0. `wb_busy` = 0.
- Latency, when `rob_entry == head` and output is free:
  - `reg0_ex_valid` in cycle N sets `done` at edge N.
  - Retire loads at edge N+1, so `wb_out_valid` is high in cycle N+2.
  - `rob_free_valid` is high in cycle N+2.
- A write to slot `head` in the cycle `head` is evaluated is not visible until the next cycle; no same-cycle bypass.
- A write to slot X and retirement of slot X in the same cycle cannot both succeed: retire requires `done[X]=1`, and the write then flags `err_dup`.
- Sustained throughput: 1 descriptor/cycle with `wb_out_ready` held high.
- Head wraps at `rob_num-1 -> 0`. `rob_num` is not required to be a power of two.
- Reset mid-operation discards all pending descriptors and the output register. No free pulses are issued for them.

## Test plan
- Single packet, `rob_entry=0`, en=1, `info=20'hABCDE`, ready=1 -> `wb_out_valid` in cycle N+2 with matching fields; `rob_free` pulse with entry 0 in N+2; `reg_free` pulse with the data_entry in N+3.
- Out-of-order completion: write slots 2, 1, 0 on consecutive cycles -> outputs in order 0, 1, 2 on consecutive cycles, first one 2 cycles after the slot-0 write.
- Back-pressure: 3 retirable slots with `wb_out_ready=0` for 5 cycles -> `wb_busy=1`; output holds slot 0 stable; no further `rob_free`; release -> 3 outputs in order.
- Wrap: 20 packets in order through slots 0..15, 0..3 -> head wraps, order preserved, `err_dup` stays 0.
- Duplicate write to an unretired slot 5 -> `err_dup=1` (sticky), original contents retire unchanged.
- Assert `rst` with 4 pending slots and `wb_out_valid=1` -> all outputs 0 immediately; new packet to slot 0 retires normally.
